// File: rtl/video_layer_mixer.sv
// Mixes LAYERS monochrome video layers into CW-bit RGB through a per-layer palette.
// Palette, mode and invert are latched at frame start; colour and timing share a 2-strobe pipeline.
module video_layer_mixer #(
    parameter int LAYERS = 3,
    parameter int CW     = 4
) (
    input  logic              clk_vid,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic [LAYERS-1:0] layer_on,
    input  logic              inv_req,
    input  logic              hblank_i,
    input  logic              vblank_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              mode_i,
    input  logic              pal_we,
    input  logic [2:0]        pal_addr,
    input  logic [3*CW-1:0]   pal_data,
    output logic [CW-1:0]     r_o,
    output logic [CW-1:0]     g_o,
    output logic [CW-1:0]     b_o,
    output logic              hblank_o,
    output logic              vblank_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              inv_o
);

    localparam int PW = 3 * CW;
    localparam int SW = CW + 3;
    localparam logic [CW-1:0] COMP_DEF = {1'b0, {(CW-1){1'b1}}};
    localparam logic [PW-1:0] PAL_DEF  = {3{COMP_DEF}};

    logic [PW-1:0]     shadow_pal_r [LAYERS];
    logic [PW-1:0]     active_pal_r [LAYERS];
    logic              shadow_mode_r;
    logic              active_mode_r;
    logic              old_vs_r;
    logic              cur_inv_r;
    logic              frame_start_s;

    logic [PW-1:0]     c_r [LAYERS];
    logic [LAYERS-1:0] on1_r;
    logic              hblank1_r;
    logic              vblank1_r;
    logic              hsync1_r;
    logic              vsync1_r;

    logic [SW-1:0]     sum_s [3];
    logic [CW-1:0]     add_s [3];
    logic [CW-1:0]     pri_s [3];
    logic [CW-1:0]     sel_s [3];
    logic [CW-1:0]     mix_s [3];

    assign frame_start_s = ce_pix & vsync_i & ~old_vs_r;

    // Palette shadow written by the OSD at full clock rate; out-of-range addresses match no entry.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAYERS; i++) shadow_pal_r[i] <= PAL_DEF;
        end else begin
            for (int i = 0; i < LAYERS; i++) begin
                if (pal_we && (pal_addr == 3'(i))) shadow_pal_r[i] <= pal_data;
            end
        end
    end

    // Frame-boundary commit of palette/mode and invert accumulation across the frame.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAYERS; i++) active_pal_r[i] <= PAL_DEF;
            shadow_mode_r <= 1'b0;
            active_mode_r <= 1'b0;
            old_vs_r      <= 1'b0;
            cur_inv_r     <= 1'b0;
            inv_o         <= 1'b0;
        end else if (ce_pix) begin
            old_vs_r      <= vsync_i;
            shadow_mode_r <= mode_i;
            if (frame_start_s) begin
                for (int i = 0; i < LAYERS; i++) active_pal_r[i] <= shadow_pal_r[i];
                active_mode_r <= shadow_mode_r;
                inv_o         <= cur_inv_r | inv_req;
                cur_inv_r     <= 1'b0;
            end else begin
                cur_inv_r     <= cur_inv_r | inv_req;
            end
        end
    end

    // Stage 1: per-layer colour lookup plus timing alignment.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAYERS; i++) c_r[i] <= {PW{1'b0}};
            on1_r     <= {LAYERS{1'b0}};
            hblank1_r <= 1'b0;
            vblank1_r <= 1'b0;
            hsync1_r  <= 1'b0;
            vsync1_r  <= 1'b0;
        end else if (ce_pix) begin
            for (int i = 0; i < LAYERS; i++) c_r[i] <= layer_on[i] ? active_pal_r[i] : {PW{1'b0}};
            on1_r     <= layer_on;
            hblank1_r <= hblank_i;
            vblank1_r <= vblank_i;
            hsync1_r  <= hsync_i;
            vsync1_r  <= vsync_i;
        end
    end

    // Stage 2 combine: k=0 blue, 1 green, 2 red; ascending scan lets the highest layer win.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            sum_s[k] = {SW{1'b0}};
            pri_s[k] = {CW{1'b0}};
            for (int i = 0; i < LAYERS; i++) begin
                sum_s[k] = sum_s[k] + {3'b000, c_r[i][k*CW +: CW]};
                if (on1_r[i]) pri_s[k] = c_r[i][k*CW +: CW];
                else          pri_s[k] = pri_s[k];
            end
            if (sum_s[k][SW-1:CW] != 3'b000) add_s[k] = {CW{1'b1}};
            else                              add_s[k] = sum_s[k][CW-1:0];
            if (active_mode_r) sel_s[k] = pri_s[k];
            else               sel_s[k] = add_s[k];
            if (hblank1_r | vblank1_r) mix_s[k] = {CW{1'b0}};
            else                        mix_s[k] = sel_s[k] ^ {CW{inv_o}};
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_o      <= {CW{1'b0}};
            g_o      <= {CW{1'b0}};
            b_o      <= {CW{1'b0}};
            hblank_o <= 1'b0;
            vblank_o <= 1'b0;
            hsync_o  <= 1'b0;
            vsync_o  <= 1'b0;
        end else if (ce_pix) begin
            r_o      <= mix_s[2];
            g_o      <= mix_s[1];
            b_o      <= mix_s[0];
            hblank_o <= hblank1_r;
            vblank_o <= vblank1_r;
            hsync_o  <= hsync1_r;
            vsync_o  <= vsync1_r;
        end
    end

endmodule

// File: tb/tb_video_layer_mixer.sv
// Scoreboard bench for video_layer_mixer: stimulus pushes hand-computed pixels, a monitor
// pops them two pixel strobes later and compares colour plus timing.
module tb_video_layer_mixer;

    localparam int LAYERS = 3;
    localparam int CW     = 4;

    logic              clk_vid = 1'b0;
    logic              reset_n;
    logic              ce_pix;
    logic [LAYERS-1:0] layer_on;
    logic              inv_req;
    logic              hblank_i, vblank_i, hsync_i, vsync_i;
    logic              mode_i;
    logic              pal_we;
    logic [2:0]        pal_addr;
    logic [3*CW-1:0]   pal_data;
    logic [CW-1:0]     r_o, g_o, b_o;
    logic              hblank_o, vblank_o, hsync_o, vsync_o, inv_o;

    always #5 clk_vid = ~clk_vid;

    video_layer_mixer #(.LAYERS(LAYERS), .CW(CW)) dut (
        .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix), .layer_on(layer_on),
        .inv_req(inv_req), .hblank_i(hblank_i), .vblank_i(vblank_i), .hsync_i(hsync_i),
        .vsync_i(vsync_i), .mode_i(mode_i), .pal_we(pal_we), .pal_addr(pal_addr),
        .pal_data(pal_data), .r_o(r_o), .g_o(g_o), .b_o(b_o), .hblank_o(hblank_o),
        .vblank_o(vblank_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .inv_o(inv_o)
    );

    typedef struct {
        int          due;
        int          id;
        logic [15:0] vec;
    } exp_t;

    exp_t        sb_q[$];
    int          strobe_n = 0;
    int          n_chk    = 0;
    int          n_fail   = 0;
    int          gap      = 1;
    int          pix_id   = 0;
    logic [15:0] out_vec;

    assign out_vec = {r_o, g_o, b_o, hblank_o, vblank_o, hsync_o, vsync_o};

    always @(posedge clk_vid) begin
        if (reset_n === 1'b1 && ce_pix === 1'b1) strobe_n++;
    end

    // Monitor: each output pixel is due two strobes after it was driven.
    always @(negedge clk_vid) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            if (sb_q[0].due <= strobe_n) begin
                e = sb_q.pop_front();
                n_chk++;
                if (out_vec !== e.vec) begin
                    n_fail++;
                    $display("FAIL pix%0d got=%h exp=%h (rgb,hb,vb,hs,vs)", e.id, out_vec, e.vec);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] lo, input logic hb, input logic vb,
                         input logic hs, input logic vs);
        layer_on = lo; hblank_i = hb; vblank_i = vb; hsync_i = hs; vsync_i = vs;
        ce_pix = 1'b1;
        @(negedge clk_vid);
        ce_pix = 1'b0;
        repeat (gap - 1) @(negedge clk_vid);
    endtask

    task automatic px(input logic [2:0] lo, input logic hb, input logic vb, input logic hs,
                      input logic vs, input logic [3:0] er, input logic [3:0] eg,
                      input logic [3:0] eb);
        exp_t e;
        e.due = strobe_n + 2;
        e.id  = pix_id;
        e.vec = {er, eg, eb, hb, vb, hs, vs};
        pix_id++;
        sb_q.push_back(e);
        drive(lo, hb, vb, hs, vs);
    endtask

    task automatic vis(input logic [2:0] lo, input logic [3:0] er, input logic [3:0] eg,
                       input logic [3:0] eb);
        px(lo, 1'b0, 1'b0, 1'b0, 1'b0, er, eg, eb);
    endtask

    task automatic frame();
        px(3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0);
        px(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        px(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic pal_write(input logic [2:0] a, input logic [11:0] d);
        @(negedge clk_vid);
        pal_we = 1'b1; pal_addr = a; pal_data = d;
        @(negedge clk_vid);
        pal_we = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; ce_pix = 1'b0; layer_on = 3'b000; inv_req = 1'b0;
        hblank_i = 1'b0; vblank_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
        mode_i = 1'b0; pal_we = 1'b0; pal_addr = 3'd0; pal_data = 12'h000;
        repeat (3) @(negedge clk_vid);
        check("reset_out", out_vec, 16'h0000);
        check("reset_inv", {15'd0, inv_o}, 16'h0000);
        reset_n = 1'b1;
        @(negedge clk_vid);

        // default palette, additive with saturation, blank forcing, timing alignment
        vis(3'b001, 4'h7, 4'h7, 4'h7);
        vis(3'b111, 4'hF, 4'hF, 4'hF);
        vis(3'b011, 4'hE, 4'hE, 4'hE);
        vis(3'b000, 4'h0, 4'h0, 4'h0);
        px(3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        px(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7, 4'h7, 4'h7);

        // shadow writes wait for the next frame; address 5 is out of range
        pal_write(3'd0, 12'h0F0);
        pal_write(3'd5, 12'h000);
        vis(3'b001, 4'h7, 4'h7, 4'h7);
        frame();
        vis(3'b001, 4'h0, 4'hF, 4'h0);
        vis(3'b010, 4'h7, 4'h7, 4'h7);
        vis(3'b100, 4'h7, 4'h7, 4'h7);
        vis(3'b111, 4'hE, 4'hF, 4'hE);

        // priority mode is shadowed as well
        pal_write(3'd0, 12'hF00);
        pal_write(3'd2, 12'h00F);
        mode_i = 1'b1;
        vis(3'b101, 4'h7, 4'hF, 4'h7);
        frame();
        vis(3'b101, 4'h0, 4'h0, 4'hF);
        vis(3'b001, 4'hF, 4'h0, 4'h0);
        vis(3'b011, 4'h7, 4'h7, 4'h7);
        vis(3'b000, 4'h0, 4'h0, 4'h0);

        // invert request in frame N applies to all of frame N+1 only
        inv_req = 1'b1;
        vis(3'b001, 4'hF, 4'h0, 4'h0);
        inv_req = 1'b0;
        vis(3'b001, 4'hF, 4'h0, 4'h0);
        check("inv_frame_n", {15'd0, inv_o}, 16'h0000);
        frame();
        check("inv_frame_n1", {15'd0, inv_o}, 16'h0001);
        vis(3'b000, 4'hF, 4'hF, 4'hF);
        vis(3'b001, 4'h0, 4'hF, 4'hF);
        px(3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        vis(3'b011, 4'h8, 4'h8, 4'h8);
        check("inv_mid_n1", {15'd0, inv_o}, 16'h0001);
        frame();
        check("inv_frame_n2", {15'd0, inv_o}, 16'h0000);
        vis(3'b000, 4'h0, 4'h0, 4'h0);

        // pixel enable every 4th clock: hsync_o must lag by exactly two strobes and hold
        gap = 4;
        vis(3'b001, 4'hF, 4'h0, 4'h0);
        vis(3'b001, 4'hF, 4'h0, 4'h0);
        px(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'h0);
        check("hs_lat_1strobe", {15'd0, hsync_o}, 16'h0000);
        vis(3'b001, 4'hF, 4'h0, 4'h0);
        check("hs_lat_2strobe", {15'd0, hsync_o}, 16'h0001);
        vis(3'b001, 4'hF, 4'h0, 4'h0);
        check("hs_lat_after", {15'd0, hsync_o}, 16'h0000);

        // asynchronous reset mid-line clears outputs and restores the default palette
        drive(3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pre_reset_drain", {12'd0, sb_q.size() == 0 ? 4'h0 : 4'h1}, 16'h0000);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_out", out_vec, 16'h0000);
        check("async_reset_inv", {15'd0, inv_o}, 16'h0000);
        mode_i = 1'b0;
        repeat (2) @(negedge clk_vid);
        reset_n = 1'b1;
        gap = 1;
        @(negedge clk_vid);
        vis(3'b001, 4'h7, 4'h7, 4'h7);
        vis(3'b111, 4'hF, 4'hF, 4'hF);
        vis(3'b100, 4'h7, 4'h7, 4'h7);

        repeat (3) drive(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL pix%0d never compared exp=%h", e.id, e.vec);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
